// File: rtl/ifu_if.sv
`default_nettype none
// ==========================================================================
// ifu_if : instruction-memory fetch bus (request/grant/rvalid handshake)
// Revision: 1.0
// ==========================================================================
interface ifu_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ==========================================================================
// ifu : RV32I fetch unit - PC, single-outstanding imem fetch, skid, redirect
// Revision: 1.0
// ==========================================================================
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_if.master       imem,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
);

  typedef enum logic [0:0] {ST_REQ = 1'b0, ST_WAIT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inflight_addr_q, inflight_addr_d;
  logic        discard_q, discard_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_addr_q, skid_addr_d;

  logic        fetch_req;
  logic        deliver;
  logic        unused_jump_lsbs;

  // Request never looks at gnt/rvalid, so there is no combinational bus loop.
  assign fetch_req        = (state_q == ST_REQ) && !skid_valid_q && !jump_en_i;
  assign imem.req         = fetch_req;
  assign imem.addr        = pc_q;
  assign unused_jump_lsbs = ^jump_addr_i[1:0];

  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign inst_addr_o  = iaddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_REQ;
      pc_q            <= RESET_PC;
      inflight_addr_q <= 32'h0;
      discard_q       <= 1'b0;
      valid_q         <= 1'b0;
      inst_q          <= NOP_INST;
      iaddr_q         <= 32'h0;
      skid_valid_q    <= 1'b0;
      skid_inst_q     <= 32'h0;
      skid_addr_q     <= 32'h0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      inflight_addr_q <= inflight_addr_d;
      discard_q       <= discard_d;
      valid_q         <= valid_d;
      inst_q          <= inst_d;
      iaddr_q         <= iaddr_d;
      skid_valid_q    <= skid_valid_d;
      skid_inst_q     <= skid_inst_d;
      skid_addr_q     <= skid_addr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    inflight_addr_d = inflight_addr_q;
    discard_d       = discard_q;
    valid_d         = valid_q;
    inst_d          = inst_q;
    iaddr_d         = iaddr_q;
    skid_valid_d    = skid_valid_q;
    skid_inst_d     = skid_inst_q;
    skid_addr_d     = skid_addr_q;
    deliver         = 1'b0;

    case (state_q)
      ST_REQ: begin
        if (fetch_req && imem.gnt) begin
          inflight_addr_d = pc_q;
          pc_d            = pc_q + 32'd4;
          state_d         = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem.rvalid) begin
          state_d = ST_REQ;
          if (discard_q || jump_en_i) begin
            discard_d = 1'b0;
          end else begin
            deliver = 1'b1;
          end
        end
      end
      default: state_d = ST_REQ;
    endcase

    // A redirect flushes everything downstream; a response still in flight is marked stale.
    if (jump_en_i) begin
      pc_d         = {jump_addr_i[31:2], 2'b00};
      valid_d      = 1'b0;
      inst_d       = NOP_INST;
      skid_valid_d = 1'b0;
      if ((state_q == ST_WAIT) && !imem.rvalid) begin
        discard_d = 1'b1;
      end
    end else if (valid_q && hold_i) begin
      if (deliver) begin
        skid_valid_d = 1'b1;
        skid_inst_d  = imem.rdata;
        skid_addr_d  = inflight_addr_q;
      end
    end else if (skid_valid_q) begin
      valid_d      = 1'b1;
      inst_d       = skid_inst_q;
      iaddr_d      = skid_addr_q;
      skid_valid_d = deliver;
      if (deliver) begin
        skid_inst_d = imem.rdata;
        skid_addr_d = inflight_addr_q;
      end
    end else if (deliver) begin
      valid_d = 1'b1;
      inst_d  = imem.rdata;
      iaddr_d = inflight_addr_q;
    end else begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ==========================================================================
// tb_ifu : directed vector tables, async-reset sequence, random vs model
// Revision: 1.0
// ==========================================================================
module tb_ifu;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic        F   = 1'b0;
  localparam logic        T   = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        hold;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  ifu_if bus ();

  ifu #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (bus),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .hold_i       (hold),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        hold;
    logic        jump;
    logic [31:0] ja;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_ia;
    logic [31:0] e_in;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, h, j, input logic [31:0] ja, input logic g, rv,
                              input logic [31:0] rd, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] eia, ein);
    vec_t x;
    x.rst = r; x.hold = h; x.jump = j; x.ja = ja; x.gnt = g; x.rv = rv; x.rd = rd;
    x.e_req = er; x.e_addr = ea; x.e_v = ev; x.e_ia = eia; x.e_in = ein;
    return x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; hold = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
    #1;
    chk("rst valid", 32'(inst_valid), 32'h0);
    chk("rst inst", inst, NOP);
    chk("rst inst_addr", inst_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst req", 32'(bus.req), 32'h1);
    chk("rst imem_addr", bus.addr, 32'h0);
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    hold = v.hold; jump_en = v.jump; jump_addr = v.ja;
    bus.gnt = v.gnt; bus.rvalid = v.rv; bus.rdata = v.rd;
    #1;
    chk({tag, " req"}, 32'(bus.req), 32'(v.e_req));
    chk({tag, " imem_addr"}, bus.addr, v.e_addr);
    @(posedge clk);
    #1;
    chk({tag, " valid"}, 32'(inst_valid), 32'(v.e_v));
    chk({tag, " inst_addr"}, inst_addr, v.e_ia);
    chk({tag, " inst"}, inst, v.e_in);
  endtask

  // Reference model state: abstract fetch/response bookkeeping with a pending queue.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } item_t;

  item_t       pend[$];
  item_t       ai;
  item_t       it;
  logic        m_busy, m_stale, m_v, arr;
  logic [31:0] m_pc, m_inflight, m_inst, m_ia;
  int          cnt;
  logic        rj, rh, rrv, rg, e_req;
  logic [31:0] rja, rrd;

  initial begin
    rst_n = 1'b0; hold = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;

    // Reset fetch, hold with skid, jump during WAIT
    vecs.push_back(mk(T,F,F,32'h0,T,F,32'h0,        T,32'h0,  F,32'h0,NOP));
    vecs.push_back(mk(F,F,F,32'h0,T,T,32'hA5A50000, F,32'h4,  T,32'h0,32'hA5A50000));
    vecs.push_back(mk(F,F,F,32'h0,T,F,32'h0,        T,32'h4,  F,32'h0,NOP));
    vecs.push_back(mk(F,F,F,32'h0,T,T,32'hA5A50004, F,32'h8,  T,32'h4,32'hA5A50004));
    vecs.push_back(mk(F,T,F,32'h0,T,F,32'h0,        T,32'h8,  T,32'h4,32'hA5A50004));
    vecs.push_back(mk(F,T,F,32'h0,T,T,32'hA5A50008, F,32'hC,  T,32'h4,32'hA5A50004));
    vecs.push_back(mk(F,T,F,32'h0,T,F,32'h0,        F,32'hC,  T,32'h4,32'hA5A50004));
    vecs.push_back(mk(F,T,F,32'h0,T,F,32'h0,        F,32'hC,  T,32'h4,32'hA5A50004));
    vecs.push_back(mk(F,F,F,32'h0,T,F,32'h0,        F,32'hC,  T,32'h8,32'hA5A50008));
    vecs.push_back(mk(F,F,F,32'h0,T,F,32'h0,        T,32'hC,  F,32'h8,NOP));
    vecs.push_back(mk(F,F,F,32'h0,T,T,32'hA5A5000C, F,32'h10, T,32'hC,32'hA5A5000C));
    vecs.push_back(mk(F,F,F,32'h0,T,F,32'h0,        T,32'h10, F,32'hC,NOP));
    vecs.push_back(mk(F,F,T,32'h200,T,F,32'h0,      F,32'h14, F,32'hC,NOP));
    vecs.push_back(mk(F,F,F,32'h0,T,T,32'hA5A50010, F,32'h200,F,32'hC,NOP));
    vecs.push_back(mk(F,F,F,32'h0,T,F,32'h0,        T,32'h200,F,32'hC,NOP));
    vecs.push_back(mk(F,F,F,32'h0,T,T,32'hA5A50200, F,32'h204,T,32'h200,32'hA5A50200));
    // Jump with skid full, jump coincident with rvalid+hold, misaligned wrap
    vecs.push_back(mk(T,F,F,32'h0,T,F,32'h0,        T,32'h0,  F,32'h0,NOP));
    vecs.push_back(mk(F,F,F,32'h0,T,T,32'hA5A50000, F,32'h4,  T,32'h0,32'hA5A50000));
    vecs.push_back(mk(F,T,F,32'h0,T,F,32'h0,        T,32'h4,  T,32'h0,32'hA5A50000));
    vecs.push_back(mk(F,T,F,32'h0,T,T,32'hA5A50004, F,32'h8,  T,32'h0,32'hA5A50000));
    vecs.push_back(mk(F,T,F,32'h0,T,F,32'h0,        F,32'h8,  T,32'h0,32'hA5A50000));
    vecs.push_back(mk(F,T,T,32'h300,T,T,32'hDEADBEEF,F,32'h8, F,32'h0,NOP));
    vecs.push_back(mk(F,F,F,32'h0,T,F,32'h0,        T,32'h300,F,32'h0,NOP));
    vecs.push_back(mk(F,F,F,32'h0,T,T,32'hA5A50300, F,32'h304,T,32'h300,32'hA5A50300));
    vecs.push_back(mk(F,T,F,32'h0,T,F,32'h0,        T,32'h304,T,32'h300,32'hA5A50300));
    vecs.push_back(mk(F,T,T,32'h400,T,T,32'hA5A50304,F,32'h308,F,32'h300,NOP));
    vecs.push_back(mk(F,F,F,32'h0,T,F,32'h0,        T,32'h400,F,32'h300,NOP));
    vecs.push_back(mk(F,F,F,32'h0,T,T,32'hA5A50400, F,32'h404,T,32'h400,32'hA5A50400));
    vecs.push_back(mk(F,F,T,32'hFFFFFFFE,T,F,32'h0, F,32'h404,F,32'h400,NOP));
    vecs.push_back(mk(F,F,F,32'h0,T,F,32'h0,        T,32'hFFFFFFFC,F,32'h400,NOP));
    vecs.push_back(mk(F,F,F,32'h0,T,T,32'h5A5AFFFC, F,32'h0,  T,32'hFFFFFFFC,32'h5A5AFFFC));
    vecs.push_back(mk(F,F,F,32'h0,T,F,32'h0,        T,32'h0,  F,32'hFFFFFFFC,NOP));
    vecs.push_back(mk(F,F,F,32'h0,T,T,32'hA5A50000, F,32'h4,  T,32'h0,32'hA5A50000));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Async reset between grant and rvalid, then a stale rvalid
    do_reset();
    for (int i = 0; i < 5; i++) step(vecs[i], $sformatf("arst%0d", i));
    @(negedge clk);
    hold = 1'b0; bus.gnt = 1'b0; bus.rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(inst_valid), 32'h0);
    chk("arst inst", inst, NOP);
    chk("arst inst_addr", inst_addr, 32'h0);
    chk("arst imem_addr", bus.addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(F,F,F,32'h0,F,T,32'hA5A50008, T,32'h0,F,32'h0,NOP), "stale");
    step(mk(F,F,F,32'h0,T,F,32'h0,        T,32'h0,F,32'h0,NOP), "arst_f0");
    step(mk(F,F,F,32'h0,T,T,32'hA5A50000, F,32'h4,T,32'h0,32'hA5A50000), "arst_f1");

    // Randomized traffic against the reference model
    do_reset();
    m_busy = 1'b0; m_stale = 1'b0; m_v = 1'b0; m_pc = 32'h0; m_inflight = 32'h0;
    m_inst = NOP; m_ia = 32'h0; cnt = 0; pend.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rj  = ($urandom_range(0, 11) == 0);
      rja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rh  = ($urandom_range(0, 2) == 0);
      if (m_busy) begin
        if (cnt > 0) cnt--;
        rrv = (cnt == 0);
        rrd = m_inflight ^ 32'hA5A5_0000;
      end else begin
        rrv = ($urandom_range(0, 15) == 0);
        rrd = $urandom;
      end
      hold = rh; jump_en = rj; jump_addr = rja; bus.rvalid = rrv; bus.rdata = rrd;
      #1;
      e_req = !m_busy && (pend.size() == 0) && !rj;
      chk($sformatf("rnd%0d req", c), 32'(bus.req), 32'(e_req));
      chk($sformatf("rnd%0d imem_addr", c), bus.addr, m_pc);
      rg = ($urandom_range(0, 3) != 0);
      bus.gnt = rg;
      @(posedge clk);
      arr = 1'b0;
      if (m_busy && rrv) begin
        m_busy = 1'b0;
        if (!m_stale && !rj) begin
          arr = 1'b1; ai.inst = rrd; ai.addr = m_inflight;
        end
        m_stale = 1'b0;
      end else if (m_busy && rj) begin
        m_stale = 1'b1;
      end
      if (e_req && rg) begin
        m_busy = 1'b1; m_inflight = m_pc; m_pc = m_pc + 32'd4; cnt = $urandom_range(1, 3);
      end
      if (rj) begin
        m_pc = {rja[31:2], 2'b00};
        pend.delete();
        m_v = 1'b0; m_inst = NOP;
      end else begin
        if (arr) pend.push_back(ai);
        if (!(m_v && rh)) begin
          if (pend.size() > 0) begin
            it = pend.pop_front();
            m_v = 1'b1; m_inst = it.inst; m_ia = it.addr;
          end else begin
            m_v = 1'b0; m_inst = NOP;
          end
        end
      end
      #1;
      chk($sformatf("rnd%0d valid", c), 32'(inst_valid), 32'(m_v));
      chk($sformatf("rnd%0d inst_addr", c), inst_addr, m_ia);
      chk($sformatf("rnd%0d inst", c), inst, m_inst);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
`default_nettype wire
